// File: rtl/pic_uart_tx_pkg.sv
// Shared constants and state encodings for the UART picture link (TX and RX sides).
// Default timing targets a 50 MHz sys_clk at 9600 baud over a 128x128 RGB332 frame.
package pic_uart_tx_pkg;

  localparam int SYS_CLK_FREQ = 50_000_000;
  localparam int UART_BAUD    = 9600;
  localparam int BIT_CYC      = SYS_CLK_FREQ / UART_BAUD;
  localparam int BAUD_CNT_W   = $clog2(BIT_CYC);
  localparam int PIC_BYTES    = 128 * 128;
  localparam int PIC_ADDR_W   = 14;

  typedef enum logic [2:0] {
    F_IDLE,
    F_FETCH,
    F_LOAD,
    F_SEND,
    F_DONE
  } frame_state_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_t;

endpackage

// File: rtl/pic_uart_tx_byte.sv
// 8N1 byte serializer with valid/ready handshake, LSB first.
// tx is registered from the current state, so the line lags the state by one cycle.
module uart_tx_byte import pic_uart_tx_pkg::*; #(
  parameter int BIT_TICKS = BIT_CYC,
  parameter int CNT_W     = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(BIT_TICKS - 1);

  byte_state_t      state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             bit_end;

  assign bit_end = (baud_cnt == LAST_TICK);
  // Ready also in the final stop-bit cycle so a waiting producer can react without a bubble.
  assign ready   = (state == B_IDLE) || ((state == B_STOP) && bit_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= B_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        B_START: tx <= 1'b0;
        B_DATA:  tx <= shreg[0];
        default: tx <= 1'b1;
      endcase

      case (state)
        B_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (valid) begin
            shreg <= data;
            state <= B_START;
          end
        end
        B_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= B_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        B_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shreg    <= {1'b0, shreg[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= B_STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        B_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (valid) begin
              shreg <= data;
              state <= B_START;
            end else begin
              state <= B_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: state <= B_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pic_uart_tx.sv
// Frame read-back: walks the picture RAM in address order and hands each byte to the
// UART serializer; FETCH covers the RAM's one-cycle read latency, LOAD presents the byte.
module pic_uart_tx import pic_uart_tx_pkg::*; #(
  parameter int CLK_FREQ = SYS_CLK_FREQ,
  parameter int BAUD     = UART_BAUD,
  parameter int PIC_SIZE = PIC_BYTES,
  parameter int ADDR_W   = PIC_ADDR_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int               BIT_TICKS = CLK_FREQ / BAUD;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIC_SIZE - 1);

  frame_state_t state;
  logic         byte_valid;
  logic         byte_ready;

  assign byte_valid = (state == F_LOAD);

  uart_tx_byte #(
    .BIT_TICKS(BIT_TICKS)
  ) u_byte (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .valid(byte_valid),
    .data (rd_data),
    .ready(byte_ready),
    .tx   (tx)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= F_IDLE;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        F_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= F_FETCH;
          end
        end
        F_FETCH: state <= F_LOAD;
        F_LOAD: begin
          if (byte_ready) begin
            state <= F_SEND;
          end
        end
        // Advance in the last stop-bit cycle so the inter-byte gap is only FETCH+LOAD.
        F_SEND: begin
          if (byte_ready) begin
            if (rd_addr == LAST_ADDR) begin
              rd_addr <= '0;
              state   <= F_DONE;
            end else begin
              rd_addr <= rd_addr + ADDR_W'(1);
              state   <= F_FETCH;
            end
          end
        end
        F_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= F_IDLE;
        end
        default: state <= F_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_uart_tx.sv
// Directed bench for pic_uart_tx with a 4-byte frame, 16 cycles per bit and a 1-cycle RAM model.
module tb_pic_uart_tx;

  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int PIC_SIZE = 4;
  localparam int ADDR_W   = 14;
  localparam int BIT_CYC  = 16;
  localparam int BYTE_CYC = 10 * BIT_CYC + 2;
  localparam int DONE_AT  = PIC_SIZE * BYTE_CYC + 1;
  localparam int LOG_N    = 1400;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              start   = 1'b0;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              tx;
  logic              busy;
  logic              done;

  logic [7:0] ram [0:3] = '{8'hA5, 8'h3C, 8'h00, 8'hFF};

  int errors = 0;
  int checks = 0;

  logic              txLog   [0:LOG_N-1];
  logic              busyLog [0:LOG_N-1];
  logic              doneLog [0:LOG_N-1];
  logic [ADDR_W-1:0] addrLog [0:LOG_N-1];
  int                startAt[$];
  int                frameBase[$];
  logic [7:0]        decoded[$];
  int                falls[$];
  int                framingBad;

  pic_uart_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .PIC_SIZE(PIC_SIZE),
    .ADDR_W  (ADDR_W)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .start  (start),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk)
    rd_data <= (rd_addr < ADDR_W'(PIC_SIZE)) ? ram[rd_addr[1:0]] : 8'hxx;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic r);
    start   = s;
    sys_rst = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic expTx(input int r);
    int j, b, p;
    if (r < 3) return 1'b1;
    j = r - 3;
    b = j / BYTE_CYC;
    p = j % BYTE_CYC;
    if (b >= PIC_SIZE) return 1'b1;
    if (p < BIT_CYC) return 1'b0;
    if (p < 9 * BIT_CYC) return ram[b][(p - BIT_CYC) / BIT_CYC];
    return 1'b1;
  endfunction

  task automatic capture(input int n);
    logic s;
    for (int k = 0; k < n; k++) begin
      txLog[k]   = tx;
      busyLog[k] = busy;
      doneLog[k] = done;
      addrLog[k] = rd_addr;
      s = 1'b0;
      foreach (startAt[i]) if (startAt[i] == k + 1) s = 1'b1;
      applyStimulus(s, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic compareModel(input int n, input string tag);
    int r, txBad, busyBad, doneBad, addrBad, firstBad;
    logic [ADDR_W-1:0] expAddr;
    txBad = 0; busyBad = 0; doneBad = 0; addrBad = 0; firstBad = -1;
    for (int k = 0; k < n; k++) begin
      r = -1;
      foreach (frameBase[i]) if (k >= frameBase[i]) r = k - frameBase[i];
      expAddr = (r < 0 || r >= PIC_SIZE * BYTE_CYC) ? '0 : ADDR_W'(r / BYTE_CYC);
      if (txLog[k] !== expTx(r)) begin
        txBad++;
        if (firstBad < 0) firstBad = k;
      end
      if (busyLog[k] !== (r >= 0 && r < DONE_AT)) busyBad++;
      if (doneLog[k] !== (r == DONE_AT)) doneBad++;
      if (addrLog[k] !== expAddr) addrBad++;
    end
    if (firstBad >= 0) $display("[TB] %s: first tx divergence at cycle %0d", tag, firstBad);
    checkOutput({tag, "_tx_wave"}, txBad, 0);
    checkOutput({tag, "_busy_wave"}, busyBad, 0);
    checkOutput({tag, "_done_wave"}, doneBad, 0);
    checkOutput({tag, "_addr_wave"}, addrBad, 0);
  endtask

  // Independent mid-bit UART decoder over the captured tx trace.
  task automatic decode(input int n);
    int k;
    logic [7:0] b;
    decoded.delete();
    falls.delete();
    framingBad = 0;
    k = 1;
    while (k + 9 * BIT_CYC + BIT_CYC / 2 < n) begin
      if (txLog[k-1] === 1'b1 && txLog[k] === 1'b0) begin
        if (txLog[k + BIT_CYC / 2] !== 1'b0) framingBad++;
        for (int i = 0; i < 8; i++) b[i] = txLog[k + BIT_CYC / 2 + BIT_CYC * (i + 1)];
        if (txLog[k + BIT_CYC / 2 + 9 * BIT_CYC] !== 1'b1) framingBad++;
        decoded.push_back(b);
        falls.push_back(k);
        k = k + 10 * BIT_CYC;
      end else begin
        k++;
      end
    end
  endtask

  initial begin
    int doneCnt, doneFirst, doneSecond, quietBad;
    logic [ADDR_W-1:0] maxAddr;

    // Reset held for three edges
    applyStimulus(1'b0, 1'b1);
    repeat (3) tick();
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_addr", rd_addr, '0);
    applyStimulus(1'b0, 1'b0);
    repeat (2) tick();

    // Frame, ignored starts at 50/648/649, back-to-back frame from 650, ignored start at 700
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    startAt = '{50, 648, 649, 650, 700};
    capture(1320);
    frameBase = '{0, 650};
    compareModel(1320, "frames");

    decode(1320);
    checkOutput("byte_count", decoded.size(), 2 * PIC_SIZE);
    for (int i = 0; i < decoded.size() && i < 2 * PIC_SIZE; i++)
      checkOutput($sformatf("byte%0d", i), decoded[i], ram[i % PIC_SIZE]);
    checkOutput("framing", framingBad, 0);
    if (falls.size() == 2 * PIC_SIZE) begin
      checkOutput("first_fall", falls[0], 3);
      checkOutput("second_frame_fall", falls[4], 650 + 3);
      for (int i = 0; i < 7; i++)
        if (i != 3) checkOutput($sformatf("byte_spacing%0d", i), falls[i+1] - falls[i], BYTE_CYC);
    end

    doneCnt = 0; doneFirst = -1; doneSecond = -1; maxAddr = '0;
    for (int k = 0; k < 1320; k++) begin
      if (doneLog[k] === 1'b1) begin
        doneCnt++;
        if (doneFirst < 0) doneFirst = k;
        else if (doneSecond < 0) doneSecond = k;
      end
      if (addrLog[k] > maxAddr) maxAddr = addrLog[k];
    end
    checkOutput("done_count", doneCnt, 2);
    checkOutput("done_first", doneFirst, DONE_AT);
    checkOutput("done_second", doneSecond, 650 + DONE_AT);
    checkOutput("addr_max", maxAddr, ADDR_W'(PIC_SIZE - 1));

    // Reset during bit 3 of byte 1
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    repeat (234) tick();
    checkOutput("mid_busy", busy, 1'b1);
    checkOutput("mid_addr", rd_addr, ADDR_W'(1));
    applyStimulus(1'b0, 1'b1);
    tick();
    checkOutput("midrst_tx", tx, 1'b1);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_addr", rd_addr, '0);
    applyStimulus(1'b0, 1'b0);
    quietBad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) quietBad++;
    end
    checkOutput("post_reset_quiet", quietBad, 0);

    // Restart after the aborted frame begins again at address 0
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    startAt.delete();
    capture(200);
    frameBase = '{0};
    compareModel(200, "restart");
    decode(200);
    checkOutput("restart_count", decoded.size(), 1);
    if (decoded.size() > 0) begin
      checkOutput("restart_byte0", decoded[0], 8'hA5);
      checkOutput("restart_fall", falls[0], 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
